mux_2to1: RTL and testbench
===========================

Name: mux_2to1

Overview:
- Parameterised 2-to-1 selector for single-bit or narrow bus signals. Used wherever a control bit picks between two data sources.
- Provides an immediate combinational output for glue logic and a registered copy for timing-closed downstream paths.
- Provides a saturating count of select transitions for debug/observability.

Parameters:
- WIDTH, 1, bit width of in0, in1, mux_out, mux_out_q.
- CNT_W, 8, width of the select-transition counter sel_toggles.

Ports:
- clk  input  1  rising-edge clock for all registered outputs.
- rst_n  input  1  asynchronous, active-low reset.
- sel  input  1  select: 0 picks in0, 1 picks in1.
- in0  input  WIDTH  data source 0.
- in1  input  WIDTH  data source 1.
- mux_out  output  WIDTH  combinational result, sel ? in1 : in0.
- mux_out_q  output  WIDTH  mux_out registered on clk.
- sel_q  output  1  sel registered on clk.
- sel_toggles  output  CNT_W  saturating count of sel changes seen at clock edges.
- inputs_differ  output  1  combinational flag; 1 when in0 != in1, meaning sel affects mux_out.

Behaviour:
- mux_out:
  - Purely combinational. No latch and no clock dependence.
  - Valid in every reset state, including while rst_n=0.
  - Changes within the same delta as sel, in0 or in1 change.
- sel is 1-bit, so there is no third state.
- If sel is X/Z in simulation, mux_out must propagate X. Do not silently pick in0.
- inputs_differ = |(in0 ^ in1). It is combinational and also unaffected by reset.
- Asynchronous reset (rst_n falling): immediately force mux_out_q=0, sel_q=0, sel_toggles=0. Hold these while rst_n=0.
- Reset release: outputs update on the first rising clk edge after rst_n returns high. Release is not required to be synchronised inside this block.
- At each rising clk edge with rst_n=1:
  - mux_out_q <= mux_out. Latency is 1 cycle from any input change.
  - sel_q <= sel.
  - If sel != sel_q and sel_toggles != all-ones, sel_toggles <= sel_toggles + 1.
- sel_toggles saturates at 2^CNT_W-1 and never wraps.
- The first edge after reset compares sel against sel_q=0. A sel held at 1 during reset therefore counts one toggle on that first edge.
- Select changes between clock edges that return to the sampled value before the next edge are not counted. Only edge-sampled values matter.
- Reset asserted mid-operation clears the registers immediately. mux_out keeps tracking its inputs.
- Width rule: WIDTH>=1 and CNT_W>=1. All data paths are bitwise; there is no sign handling.

Test Plan:
- Combinational sweep, WIDTH=1, rst_n=0, no clock: drive {sel,in1,in0}=0..7, 100 ns each. Required mux_out sequence is 0,1,0,1,0,0,1,1. Required inputs_differ sequence is 0,1,1,0,0,1,1,0.
- Registered path: rst_n=1, in0=0, in1=1, sel 0->1 mid-cycle. mux_out goes to 1 immediately; mux_out_q goes to 1 at the next rising edge, not before. sel_q goes to 1 at the same edge.
- Toggle counting, CNT_W=2: toggle sel every cycle for 6 cycles. sel_toggles reads 1,2,3,3,3,3 and saturates without wrapping.
- Async reset mid-run: mux_out_q=1 and sel_toggles=2, then pull rst_n low between edges. mux_out_q=0, sel_q=0 and sel_toggles=0 with no clock edge, while mux_out still equals sel?in1:in0.
- Bus width, WIDTH=8: in0=0xA5, in1=0x3C. With sel=0, mux_out=0xA5; with sel=1, mux_out=0x3C. inputs_differ=1 in both cases. mux_out_q follows one cycle later.
- Glitch between edges: sel pulses 0->1->0 entirely between two rising edges. sel_toggles is unchanged, and mux_out showed in1 only during the pulse.

Source files
------------

// File: rtl/mux_2to1.sv
// Parameterised 2-to-1 selector with a combinational output, a registered copy,
// and a saturating counter of sampled select transitions for debug visibility.
module mux_2to1 #(
   parameter int WIDTH = 1,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             sel,
   input  logic [WIDTH-1:0] in0,
   input  logic [WIDTH-1:0] in1,
   output logic [WIDTH-1:0] mux_out,
   output logic [WIDTH-1:0] mux_out_q,
   output logic             sel_q,
   output logic [CNT_W-1:0] sel_toggles,
   output logic             inputs_differ
);

   // The conditional operator keeps an unknown select visible as X instead of defaulting to in0.
   assign mux_out       = sel ? in1 : in0;
   assign inputs_differ = |(in0 ^ in1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mux_out_q   <= '0;
         sel_q       <= 1'b0;
         sel_toggles <= '0;
      end else begin
         mux_out_q <= mux_out;
         sel_q     <= sel;
         if ((sel != sel_q) && (sel_toggles != {CNT_W{1'b1}}))
            sel_toggles <= sel_toggles + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_mux_2to1.sv
// Self-checking bench for mux_2to1: a narrow instance with a 2-bit counter and a
// byte-wide instance, checked against a behavioural model plus literal expectations.
module tb_mux_2to1;

   logic       clk;
   logic       clk_en;
   logic       rst_n;
   logic       sel;
   logic       a_in0, a_in1;
   logic [7:0] b_in0, b_in1;

   logic       a_out, a_out_q, a_sel_q, a_diff;
   logic [1:0] a_tog;
   logic [7:0] b_out, b_out_q, b_tog;
   logic       b_sel_q, b_diff;

   int errors = 0;
   int checks = 0;
   bit check_en = 0;

   // Behavioural model state: plain integers for the counters, saturation by comparison.
   int         m_a_tog, m_b_tog;
   logic       m_sel_q;
   logic       m_a_q;
   logic [7:0] m_b_q;

   mux_2to1 #(.WIDTH(1), .CNT_W(2)) dut_a (
      .clk(clk), .rst_n(rst_n), .sel(sel), .in0(a_in0), .in1(a_in1),
      .mux_out(a_out), .mux_out_q(a_out_q), .sel_q(a_sel_q),
      .sel_toggles(a_tog), .inputs_differ(a_diff)
   );

   mux_2to1 #(.WIDTH(8), .CNT_W(8)) dut_b (
      .clk(clk), .rst_n(rst_n), .sel(sel), .in0(b_in0), .in1(b_in1),
      .mux_out(b_out), .mux_out_q(b_out_q), .sel_q(b_sel_q),
      .sel_toggles(b_tog), .inputs_differ(b_diff)
   );

   initial clk = 1'b0;
   always begin
      #5;
      if (clk_en) clk = ~clk;
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic applyStimulus(input logic s, input logic ai0, input logic ai1,
                                input logic [7:0] bi0, input logic [7:0] bi1);
      sel   = s;
      a_in0 = ai0;
      a_in1 = ai1;
      b_in0 = bi0;
      b_in1 = bi1;
   endtask

   // Model: registers capture the selected source and count sampled select changes.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_a_tog = 0;
         m_b_tog = 0;
         m_sel_q = 1'b0;
         m_a_q   = 1'b0;
         m_b_q   = 8'h00;
      end else begin
         if (sel != m_sel_q) begin
            if (m_a_tog < 3)   m_a_tog = m_a_tog + 1;
            if (m_b_tog < 255) m_b_tog = m_b_tog + 1;
         end
         m_sel_q = sel;
         m_a_q   = (sel == 1'b1) ? a_in1 : a_in0;
         m_b_q   = (sel == 1'b1) ? b_in1 : b_in0;
      end
   end

   always @(negedge clk) begin
      if (check_en) begin
         checkOutput("a_mux_out", 32'(a_out), 32'((sel == 1'b1) ? a_in1 : a_in0));
         checkOutput("b_mux_out", 32'(b_out), 32'((sel == 1'b1) ? b_in1 : b_in0));
         checkOutput("a_diff", 32'(a_diff), 32'(a_in0 != a_in1));
         checkOutput("b_diff", 32'(b_diff), 32'(b_in0 != b_in1));
         checkOutput("a_mux_out_q", 32'(a_out_q), 32'(m_a_q));
         checkOutput("b_mux_out_q", 32'(b_out_q), 32'(m_b_q));
         checkOutput("a_sel_q", 32'(a_sel_q), 32'(m_sel_q));
         checkOutput("b_sel_q", 32'(b_sel_q), 32'(m_sel_q));
         checkOutput("a_sel_toggles", 32'(a_tog), 32'(m_a_tog));
         checkOutput("b_sel_toggles", 32'(b_tog), 32'(m_b_tog));
      end
   end

   initial begin
      logic [7:0] sweep_out;
      logic [7:0] sweep_diff;
      logic [3:0] tog_exp [6];
      logic [2:0] v;
      sweep_out  = 8'b1100_1010;
      sweep_diff = 8'b0110_0110;
      tog_exp    = '{4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd3};

      clk_en = 1'b0;
      rst_n  = 1'b0;
      applyStimulus(1'b0, 1'b0, 1'b0, 8'hA5, 8'h3C);
      #10;

      // Combinational sweep while held in reset with no clock running.
      for (int i = 0; i < 8; i++) begin
         v = 3'(i);
         applyStimulus(v[2], v[0], v[1], 8'hA5, 8'h3C);
         #100;
         checkOutput("sweep_mux_out", 32'(a_out), 32'(sweep_out[i]));
         checkOutput("sweep_diff", 32'(a_diff), 32'(sweep_diff[i]));
         checkOutput("sweep_q_reset", 32'(a_out_q), 32'd0);
         checkOutput("sweep_tog_reset", 32'(a_tog), 32'd0);
      end

      applyStimulus(1'b0, 1'b0, 1'b1, 8'hA5, 8'h3C);
      #2;
      rst_n = 1'b1;
      clk_en = 1'b1;
      check_en = 1'b1;
      repeat (2) @(negedge clk);

      // Registered path: select flips mid-cycle, register follows at the next edge.
      #2;
      sel = 1'b1;
      #1;
      checkOutput("reg_mux_out_now", 32'(a_out), 32'd1);
      checkOutput("reg_q_before_edge", 32'(a_out_q), 32'd0);
      checkOutput("reg_sel_q_before", 32'(a_sel_q), 32'd0);
      @(posedge clk);
      #1;
      checkOutput("reg_q_after_edge", 32'(a_out_q), 32'd1);
      checkOutput("reg_sel_q_after", 32'(a_sel_q), 32'd1);
      checkOutput("reg_tog_one", 32'(a_tog), 32'd1);

      @(negedge clk);
      #1;
      applyStimulus(1'b0, 1'b1, 1'b1, 8'hA5, 8'h3C);
      @(posedge clk);
      #1;
      checkOutput("pre_rst_q", 32'(a_out_q), 32'd1);
      checkOutput("pre_rst_tog", 32'(a_tog), 32'd2);

      // Asynchronous reset between edges clears registers at once.
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("arst_q", 32'(a_out_q), 32'd0);
      checkOutput("arst_sel_q", 32'(a_sel_q), 32'd0);
      checkOutput("arst_tog", 32'(a_tog), 32'd0);
      checkOutput("arst_b_tog", 32'(b_tog), 32'd0);
      checkOutput("arst_mux_out", 32'(a_out), 32'd1);
      checkOutput("arst_b_mux_out", 32'(b_out), 32'hA5);
      @(negedge clk);
      #1;
      applyStimulus(1'b0, 1'b0, 1'b1, 8'hA5, 8'h3C);
      rst_n = 1'b1;

      // Toggle every cycle: narrow counter saturates at 3, wide one keeps counting.
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         #1;
         sel = ~sel;
         @(posedge clk);
         #1;
         checkOutput("tog_a", 32'(a_tog), 32'(tog_exp[i]));
         checkOutput("tog_b", 32'(b_tog), 32'(i + 1));
      end

      // Byte-wide selection.
      #1;
      checkOutput("bus_sel0", 32'(b_out), 32'hA5);
      checkOutput("bus_diff0", 32'(b_diff), 32'd1);
      @(negedge clk);
      #1;
      sel = 1'b1;
      #1;
      checkOutput("bus_sel1", 32'(b_out), 32'h3C);
      checkOutput("bus_diff1", 32'(b_diff), 32'd1);
      checkOutput("bus_q_lag", 32'(b_out_q), 32'hA5);
      @(posedge clk);
      #1;
      checkOutput("bus_q_follow", 32'(b_out_q), 32'h3C);
      checkOutput("bus_tog7", 32'(b_tog), 32'd7);
      @(negedge clk);
      #1;
      sel = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("bus_tog8", 32'(b_tog), 32'd8);

      // Glitch between edges: visible on mux_out, invisible to the counter.
      @(negedge clk);
      #1;
      sel = 1'b1;
      #1;
      checkOutput("glitch_out_hi", 32'(a_out), 32'd1);
      checkOutput("glitch_b_out_hi", 32'(b_out), 32'h3C);
      #1;
      sel = 1'b0;
      #1;
      checkOutput("glitch_out_lo", 32'(a_out), 32'd0);
      @(posedge clk);
      #1;
      checkOutput("glitch_tog_b", 32'(b_tog), 32'd8);
      checkOutput("glitch_tog_a", 32'(a_tog), 32'd3);

      repeat (3) @(negedge clk);
      #1;
      check_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
